// File: rtl/axis_bayer_frame_ctl_if.sv
// axis_bayer_frame_ctl_if: AXI4-Stream pixel bus (tuser = SOF, tlast = EOL) with master/slave views
interface axis_bayer_frame_ctl_if #(parameter int C_PIXEL_WIDTH = 8);
  logic tvalid;
  logic [C_PIXEL_WIDTH-1:0] tdata;
  logic tuser;
  logic tlast;
  logic tready;
  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_bayer_frame_ctl.sv
// axis_bayer_frame_ctl: frame gate and bayer-phase latch ahead of the extractor; define AXIS_BAYER_CTL_SIZE_CHECK_EN for geometry errors and early-SOF restart
module axis_bayer_frame_ctl #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS = 12,
  parameter int C_IMG_HBITS = 12
) (
  input  logic clk,
  input  logic resetn,
  axis_bayer_frame_ctl_if.slave s_axis,
  axis_bayer_frame_ctl_if.master m_axis,
  input  logic [C_IMG_WBITS-1:0] cfg_width,
  input  logic [C_IMG_HBITS-1:0] cfg_height,
  input  logic cfg_col_odd,
  input  logic cfg_row_odd,
  input  logic cfg_oneshot,
  input  logic start,
  input  logic stop,
  output logic bayer_col_odd,
  output logic bayer_row_odd,
  output logic busy,
  output logic frame_done,
  output logic [15:0] frame_cnt,
  output logic err_width,
  output logic err_height
);
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [C_IMG_WBITS-1:0] pix_cnt, pc;
  logic [C_IMG_HBITS-1:0] line_cnt, height_q, lc, h;
  logic stop_pend, sof_seen, acc, relatch, frame_end, run;
  assign acc = state == ACTIVE && s_axis.tvalid && m_axis.tready;
  assign run = state == IDLE && start && !stop;
`ifdef AXIS_BAYER_CTL_SIZE_CHECK_EN
  logic [C_IMG_WBITS-1:0] width_q, w;
  assign relatch = acc && s_axis.tuser;
  assign w = relatch ? cfg_width : width_q;
`else
  logic unused_cfg_width;
  assign relatch = acc && s_axis.tuser && !sof_seen;
  assign unused_cfg_width = ^cfg_width;
`endif
  assign pc = relatch ? C_IMG_WBITS'(1) : pix_cnt + C_IMG_WBITS'(1);
  assign lc = relatch ? '0 : line_cnt;
  assign h = relatch ? cfg_height : height_q;
  assign frame_end = acc && s_axis.tlast && lc == h - C_IMG_HBITS'(1);
  assign busy = state != IDLE;
  // state register
  always_ff @(posedge clk) state <= !resetn ? IDLE : state_nxt;
  // next state, stream gating and frame-end pulse
  always_comb begin
    state_nxt = state;
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata = '0;
    m_axis.tuser = 1'b0;
    m_axis.tlast = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: state_nxt = run ? WAIT_SOF : IDLE;
      WAIT_SOF: begin
        s_axis.tready = !(s_axis.tvalid && s_axis.tuser);
        state_nxt = stop ? IDLE : s_axis.tvalid && s_axis.tuser ? ACTIVE : WAIT_SOF;
      end
      default: begin
        s_axis.tready = m_axis.tready;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata = s_axis.tdata;
        m_axis.tuser = s_axis.tuser;
        m_axis.tlast = s_axis.tlast;
        frame_done = frame_end;
        state_nxt = !frame_end ? ACTIVE : stop_pend || stop || cfg_oneshot ? IDLE : WAIT_SOF;
      end
    endcase
  end
  // SOF latch of phase/geometry, pixel/line counters, frame count and stop request
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_cnt <= '0;
      line_cnt <= '0;
      height_q <= '0;
      bayer_col_odd <= 1'b0;
      bayer_row_odd <= 1'b0;
      frame_cnt <= '0;
      stop_pend <= 1'b0;
      sof_seen <= 1'b0;
    end else begin
      stop_pend <= run ? 1'b0 : stop_pend || (state == ACTIVE && stop);
      sof_seen <= state == ACTIVE && (sof_seen || acc);
      if (relatch) begin
        bayer_col_odd <= cfg_col_odd;
        bayer_row_odd <= cfg_row_odd;
        height_q <= cfg_height;
      end
      if (acc) begin
        pix_cnt <= s_axis.tlast ? '0 : pc;
        line_cnt <= s_axis.tlast ? lc + C_IMG_HBITS'(1) : lc;
      end
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`ifdef AXIS_BAYER_CTL_SIZE_CHECK_EN
  // sticky geometry errors, cleared when a new run starts
  always_ff @(posedge clk) begin
    if (!resetn) begin
      width_q <= '0;
      err_width <= 1'b0;
      err_height <= 1'b0;
    end else begin
      if (relatch) width_q <= cfg_width;
      err_width <= !run && (err_width || (acc && s_axis.tlast && pc != w));
      err_height <= !run && (err_height || (relatch && sof_seen));
    end
  end
`else
  assign err_width = 1'b0;
  assign err_height = 1'b0;
`endif
endmodule

// File: tb/tb_axis_bayer_frame_ctl.sv
// tb_axis_bayer_frame_ctl: vector table, directed corner cases and randomized frames against a stream-level model
module tb_axis_bayer_frame_ctl;
`ifdef AXIS_BAYER_CTL_SIZE_CHECK_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic [11:0] cfg_width = 12'd4, cfg_height = 12'd2;
  logic cfg_col_odd = 1'b0, cfg_row_odd = 1'b0, cfg_oneshot = 1'b0, start = 1'b0, stop = 1'b0;
  logic bayer_col_odd, bayer_row_odd, busy, frame_done, err_width, err_height;
  logic [15:0] frame_cnt;
  axis_bayer_frame_ctl_if #(.C_PIXEL_WIDTH(8)) s_if();
  axis_bayer_frame_ctl_if #(.C_PIXEL_WIDTH(8)) m_if();
  axis_bayer_frame_ctl dut (
    .clk(clk), .resetn(resetn), .s_axis(s_if), .m_axis(m_if),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_col_odd(cfg_col_odd),
    .cfg_row_odd(cfg_row_odd), .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop),
    .bayer_col_odd(bayer_col_odd), .bayer_row_odd(bayer_row_odd), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_width(err_width), .err_height(err_height)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0, done_seen = 0;
  bit mon_en = 0, rnd_rdy = 0;
  logic [9:0] exp_q[$];
  typedef struct { logic [4:0] in; logic [7:0] d; logic r; logic [3:0] ex; } vec_t;
  typedef struct { logic [7:0] d; logic u, l; int w, h; } beat_t;
  vec_t tbl[17];
  beat_t bq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick(output bit a);
    if (rnd_rdy) m_if.tready = $urandom_range(0, 3) != 0;
    #1;
    a = s_if.tvalid && s_if.tready;
    if (frame_done) done_seen++;
    if (mon_en && m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL stream_extra_beat: got %0h expected no beat", {m_if.tuser, m_if.tlast, m_if.tdata});
      end else chk("stream_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q.pop_front());
    end
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic u, input logic l);
    bit a;
    int n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata = d;
    s_if.tuser = u;
    s_if.tlast = l;
    do begin
      tick(a);
      n++;
    end while (!a && n < 64);
    chk("send_accept", a, 1);
  endtask
  task automatic pulse_start();
    bit a;
    s_if.tvalid = 1'b0;
    start = 1'b1;
    tick(a);
    start = 1'b0;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    {start, stop, s_if.tvalid, s_if.tuser, s_if.tlast} = '0;
    s_if.tdata = '0;
    m_if.tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    bit a;
    int base, exp_frames, lines;
    bit hunting;
    tbl[0] = '{5'b11000, 8'h00, 1'b1, 4'b0000};
    tbl[1] = '{5'b00110, 8'h10, 1'b1, 4'b0000};
    tbl[2] = '{5'b10000, 8'h00, 1'b1, 4'b0000};
    tbl[3] = '{5'b00100, 8'hAA, 1'b1, 4'b1010};
    tbl[4] = '{5'b00100, 8'hAB, 1'b0, 4'b1010};
    tbl[5] = '{5'b00110, 8'h10, 1'b1, 4'b0010};
    tbl[6] = '{5'b00110, 8'h10, 1'b1, 4'b1110};
    tbl[7] = '{5'b00100, 8'h11, 1'b0, 4'b0110};
    tbl[8] = '{5'b00100, 8'h11, 1'b1, 4'b1110};
    tbl[9] = '{5'b01100, 8'h12, 1'b1, 4'b1110};
    tbl[10] = '{5'b00101, 8'h13, 1'b1, 4'b1110};
    tbl[11] = '{5'b00100, 8'h14, 1'b0, 4'b0110};
    tbl[12] = '{5'b00100, 8'h14, 1'b1, 4'b1110};
    tbl[13] = '{5'b00100, 8'h15, 1'b1, 4'b1110};
    tbl[14] = '{5'b00100, 8'h16, 1'b1, 4'b1110};
    tbl[15] = '{5'b00101, 8'h17, 1'b1, 4'b1111};
    tbl[16] = '{5'b00110, 8'h20, 1'b1, 4'b0000};
    cfg_col_odd = 1'b1;
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_errs", {err_width, err_height}, 0);
    chk("rst_bayer", {bayer_col_odd, bayer_row_odd}, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk);
    foreach (tbl[i]) begin
      {start, stop, s_if.tvalid, s_if.tuser, s_if.tlast} = tbl[i].in;
      s_if.tdata = tbl[i].d;
      m_if.tready = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_s_tready", i), s_if.tready, tbl[i].ex[3]);
      chk($sformatf("tbl%0d_m_tvalid", i), m_if.tvalid, tbl[i].ex[2]);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ex[1]);
      chk($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].ex[0]);
      if (tbl[i].ex[2]) chk($sformatf("tbl%0d_m_beat", i), {m_if.tuser, m_if.tlast, m_if.tdata}, {tbl[i].in[1:0], tbl[i].d});
      @(negedge clk);
    end
    chk("tbl_frame_cnt", frame_cnt, 1);
    chk("tbl_bayer", {bayer_col_odd, bayer_row_odd}, 2'b10);
    chk("tbl_errs", {err_width, err_height}, 0);
    do_reset();
    cfg_width = 12'd2;
    cfg_height = 12'd2;
    cfg_col_odd = 1'b1;
    cfg_row_odd = 1'b0;
    cfg_oneshot = 1'b1;
    done_seen = 0;
    pulse_start();
    send(8'h30, 1'b1, 1'b0);
    chk("phase_sof", {bayer_col_odd, bayer_row_odd}, 2'b10);
    cfg_col_odd = 1'b0;
    cfg_row_odd = 1'b1;
    send(8'h31, 1'b0, 1'b1);
    chk("phase_mid", {bayer_col_odd, bayer_row_odd}, 2'b10);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b1);
    s_if.tuser = 1'b1;
    #1;
    chk("oneshot_busy", busy, 0);
    chk("oneshot_idle_tready", s_if.tready, 0);
    chk("oneshot_phase_end", {bayer_col_odd, bayer_row_odd}, 2'b10);
    chk("oneshot_frame_cnt", frame_cnt, 1);
    chk("oneshot_done_pulses", done_seen, 1);
    @(negedge clk);
    do_reset();
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    pulse_start();
    send(8'h00, 1'b1, 1'b0);
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b1);
    chk("err_width_short_line", err_width, SC);
    chk("err_height_before_sof", err_height, 0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0);
    chk("err_height_early_sof", err_height, SC);
    send(8'h06, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b1);
    chk("err_line_after_restart", busy, SC);
`ifdef AXIS_BAYER_CTL_SIZE_CHECK_EN
    send(8'h09, 1'b0, 1'b0);
    send(8'h0a, 1'b0, 1'b0);
    send(8'h0b, 1'b0, 1'b0);
    send(8'h0c, 1'b0, 1'b1);
`endif
    s_if.tvalid = 1'b0;
    #1;
    chk("err_frame_end_idle", busy, 0);
    chk("err_frame_cnt", frame_cnt, 1);
    chk("err_sticky", {err_width, err_height}, {SC, SC});
    @(negedge clk);
    pulse_start();
    #1;
    chk("err_cleared_by_start", {err_width, err_height}, 0);
    chk("err_restart_busy", busy, 1);
    @(negedge clk);
    stop = 1'b1;
    tick(a);
    stop = 1'b0;
    #1;
    chk("wait_sof_stop", busy, 0);
    @(negedge clk);
    do_reset();
    force dut.frame_cnt = 16'hffff;
    @(negedge clk);
    release dut.frame_cnt;
    cfg_width = 12'd2;
    cfg_height = 12'd1;
    pulse_start();
    send(8'h40, 1'b1, 1'b0);
    send(8'h41, 1'b0, 1'b1);
    chk("wrap_frame_cnt", frame_cnt, 0);
    cfg_oneshot = 1'b0;
    cfg_col_odd = 1'b1;
    cfg_width = 12'd4;
    pulse_start();
    send(8'h50, 1'b1, 1'b0);
    send(8'h51, 1'b0, 1'b0);
    #1;
    chk("pre_reset_m_tvalid", m_if.tvalid, 1);
    chk("pre_reset_bayer", bayer_col_odd, 1);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_reset_m_tvalid", m_if.tvalid, 0);
    chk("mid_reset_s_tready", s_if.tready, 0);
    chk("mid_reset_status", {busy, frame_done, err_width, err_height, bayer_col_odd, bayer_row_odd}, 0);
    chk("mid_reset_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    do_reset();
    for (int f = 0; f < 40; f++) begin
      int w = $urandom_range(2, 5), h = $urandom_range(1, 3), junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) bq.push_back('{8'($urandom), 1'b0, 1'($urandom), w, h});
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) bq.push_back('{8'($urandom), x == 0 && y == 0, x == w - 1, w, h});
    end
    hunting = 1;
    lines = 0;
    exp_frames = 0;
    foreach (bq[i]) begin
      if (hunting && !bq[i].u) continue;
      if (hunting) begin
        hunting = 0;
        lines = 0;
      end
      exp_q.push_back({bq[i].u, bq[i].l, bq[i].d});
      if (bq[i].l) lines++;
      if (lines == bq[i].h) begin
        hunting = 1;
        exp_frames++;
      end
    end
    base = done_seen;
    mon_en = 1;
    rnd_rdy = 1;
    pulse_start();
    foreach (bq[i]) begin
      cfg_width = 12'(bq[i].w);
      cfg_height = 12'(bq[i].h);
      send(bq[i].d, bq[i].u, bq[i].l);
    end
    s_if.tvalid = 1'b0;
    repeat (4) tick(a);
    chk("rnd_stream_drained", exp_q.size(), 0);
    chk("rnd_done_pulses", done_seen - base, exp_frames);
    chk("rnd_frame_cnt", frame_cnt, exp_frames);
    chk("rnd_errs", {err_width, err_height}, 0);
    chk("rnd_wait_sof_busy", busy, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
